// File: rtl/tnnzeq_pkg.sv
// Shared definitions for the ternary sparse second layer: FSM encoding,
// score width and ternary weight decode.
package tnnzeq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC    = 2'd1,
        ARGMAX = 2'd2,
        DONE   = 2'd3
    } state_t;

    // A sum of n terms in {-1,0,+1} spans [-n, n]; one extra bit for the sign.
    function automatic int unsigned score_width(input int unsigned n);
        return $clog2(n + 1) + 1;
    endfunction

    // mask=0 -> 0, otherwise val=1 -> +1, val=0 -> -1.
    function automatic logic signed [1:0] weight_decode(input logic mask, input logic val);
        if (!mask) begin
            return 2'sd0;
        end
        return val ? 2'sd1 : -2'sd1;
    endfunction

endpackage

// File: rtl/class_acc_tnnzeq.sv
// One class score accumulator: adds weight(hidx) * act(hidden[hidx]) per enabled cycle.
module class_acc_tnnzeq
    import tnnzeq_pkg::*;
#(
    parameter int unsigned HIDDEN_CNT = 4,
    parameter int unsigned SW = 4,
    parameter logic [HIDDEN_CNT-1:0] MASK = '0,
    parameter logic [HIDDEN_CNT-1:0] SPARSE_VALS = '0,
    localparam int unsigned HIW = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [HIW-1:0]        hidx,
    input  logic [HIDDEN_CNT-1:0] hidden,
    output logic signed [SW-1:0]  score
);

    logic signed [1:0] w_c;
    logic signed [1:0] term_c;

    // Activation bit 1 keeps the weight sign, bit 0 flips it.
    always_comb begin
        w_c    = weight_decode(MASK[hidx], SPARSE_VALS[hidx]);
        term_c = hidden[hidx] ? w_c : -w_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score <= '0;
        end else if (clr) begin
            score <= '0;
        end else if (en) begin
            score <= score + SW'(term_c);
        end
    end

endmodule

// File: rtl/second_layer_tnnzeq.sv
// Ternary sparse second layer: serial accumulate over hidden units, then argmax.
// Optional macro TNNZEQ_SCORE_OUT_EN exposes the live score registers on port scores.
module second_layer_tnnzeq
    import tnnzeq_pkg::*;
#(
    parameter int unsigned HIDDEN_CNT = 4,
    parameter int unsigned CLASS_CNT = 3,
    parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] MASK = '0,
    parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] SPARSE_VALS = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [HIDDEN_CNT-1:0]        hidden,
    output logic [$clog2(CLASS_CNT)-1:0] out,
    output logic                         done
`ifdef TNNZEQ_SCORE_OUT_EN
    ,
    output logic [CLASS_CNT*score_width(HIDDEN_CNT)-1:0] scores
`endif
);

    localparam int unsigned SW  = score_width(HIDDEN_CNT);
    localparam int unsigned HIW = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1;
    localparam int unsigned CW  = $clog2(CLASS_CNT);

    state_t                state_q, state_d;
    logic [HIW-1:0]        hidx_q, hidx_d;
    logic [CW-1:0]         cidx_q, cidx_d;
    logic [CW-1:0]         best_q, best_d;
    logic [CW-1:0]         out_d;
    logic                  done_d;
    logic [HIDDEN_CNT-1:0] hidden_q, hidden_d;
    logic                  acc_clr_c;
    logic                  acc_en_c;
    logic signed [SW-1:0]  score [CLASS_CNT];

    for (genvar c = 0; c < CLASS_CNT; c++) begin : g_class
        class_acc_tnnzeq #(
            .HIDDEN_CNT (HIDDEN_CNT),
            .SW         (SW),
            .MASK       (MASK[c*HIDDEN_CNT +: HIDDEN_CNT]),
            .SPARSE_VALS(SPARSE_VALS[c*HIDDEN_CNT +: HIDDEN_CNT])
        ) u_acc (
            .clk   (clk),
            .rst   (rst),
            .clr   (acc_clr_c),
            .en    (acc_en_c),
            .hidx  (hidx_q),
            .hidden(hidden_q),
            .score (score[c])
        );
`ifdef TNNZEQ_SCORE_OUT_EN
        assign scores[c*SW +: SW] = score[c];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hidx_q   <= '0;
            cidx_q   <= '0;
            best_q   <= '0;
            hidden_q <= '0;
            out      <= '0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            hidx_q   <= hidx_d;
            cidx_q   <= cidx_d;
            best_q   <= best_d;
            hidden_q <= hidden_d;
            out      <= out_d;
            done     <= done_d;
        end
    end

    // Next-state and datapath control; DONE is terminal until reset.
    always_comb begin
        state_d   = state_q;
        hidx_d    = hidx_q;
        cidx_d    = cidx_q;
        best_d    = best_q;
        hidden_d  = hidden_q;
        out_d     = out;
        done_d    = done;
        acc_clr_c = 1'b0;
        acc_en_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    hidden_d  = hidden;
                    acc_clr_c = 1'b1;
                    hidx_d    = '0;
                    state_d   = ACC;
                end
            end
            ACC: begin
                acc_en_c = 1'b1;
                if (hidx_q == HIW'(HIDDEN_CNT - 1)) begin
                    best_d  = '0;
                    cidx_d  = CW'(1);
                    state_d = ARGMAX;
                end else begin
                    hidx_d = hidx_q + HIW'(1);
                end
            end
            ARGMAX: begin
                // Strict compare keeps the lowest index on ties.
                if (score[cidx_q] > score[best_q]) begin
                    best_d = cidx_q;
                end
                if (cidx_q == CW'(CLASS_CNT - 1)) begin
                    out_d   = best_d;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cidx_d = cidx_q + CW'(1);
                end
            end
            DONE: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_second_layer_tnnzeq.sv
// Directed bench for second_layer_tnnzeq: vector table plus reset/toggle corner sequences.
module tb_second_layer_tnnzeq;

    localparam int unsigned H = 4;
    localparam int unsigned C = 3;
    localparam int unsigned SW = 4;
    // class0 all +1, class1 all -1, class2 all 0
    localparam logic [C*H-1:0] MASK_MAIN = 12'h0FF;
    localparam logic [C*H-1:0] VALS_MAIN = 12'h00F;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [H-1:0] hidden;
    logic [1:0] out, out_z;
    logic done, done_z;
`ifdef TNNZEQ_SCORE_OUT_EN
    logic [C*SW-1:0] scores, scores_z;
`endif

    always #5 clk = ~clk;

    second_layer_tnnzeq #(
        .HIDDEN_CNT(H), .CLASS_CNT(C), .MASK(MASK_MAIN), .SPARSE_VALS(VALS_MAIN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .hidden(hidden), .out(out), .done(done)
`ifdef TNNZEQ_SCORE_OUT_EN
        , .scores(scores)
`endif
    );

    second_layer_tnnzeq #(
        .HIDDEN_CNT(H), .CLASS_CNT(C), .MASK(12'h000), .SPARSE_VALS(VALS_MAIN)
    ) dut_z (
        .clk(clk), .rst(rst), .start(start), .hidden(hidden), .out(out_z), .done(done_z)
`ifdef TNNZEQ_SCORE_OUT_EN
        , .scores(scores_z)
`endif
    );

    typedef struct {
        logic [H-1:0] hidden;
        logic [1:0]   exp_out;
    } vec_t;

    vec_t vecs[8];
    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Holds reset for two cycles and checks the reset outputs while it is asserted.
    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        hidden = '0;
        @(negedge clk);
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_done_z", 32'(done_z), 32'd0);
`ifdef TNNZEQ_SCORE_OUT_EN
        check("rst_scores", 32'(scores), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called #1 after the edge that sampled start; counts edges until done rises.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        vecs[0] = '{4'b1111, 2'd0};
        vecs[1] = '{4'b0000, 2'd1};
        vecs[2] = '{4'b0001, 2'd1};
        vecs[3] = '{4'b0111, 2'd0};
        vecs[4] = '{4'b1010, 2'd0};
        vecs[5] = '{4'b1000, 2'd1};
        vecs[6] = '{4'b0110, 2'd0};
        vecs[7] = '{4'b1110, 2'd0};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            @(negedge clk);
            start = 1'b1;
            hidden = vecs[i].hidden;
            @(posedge clk);
            #1;
            check("early_done", 32'(done), 32'd0);
            check("early_out", 32'(out), 32'd0);
            wait_done(lat);
            check($sformatf("latency[%0d]", i), 32'(lat), 32'd6);
            check($sformatf("out[%0d]", i), 32'(out), 32'(vecs[i].exp_out));
            check($sformatf("done_z[%0d]", i), 32'(done_z), 32'd1);
            check($sformatf("out_z[%0d]", i), 32'(out_z), 32'd0);
`ifdef TNNZEQ_SCORE_OUT_EN
            if (vecs[i].hidden == 4'b1010) begin
                check("scores_1010", 32'(scores), 32'h000);
            end
            if (vecs[i].hidden == 4'b1111) begin
                check("scores_1111", 32'(scores), 32'h0C4);
            end
            if (vecs[i].hidden == 4'b0000) begin
                check("scores_0000", 32'(scores), 32'h04C);
            end
`endif
            @(negedge clk);
            start = 1'b0;
        end

        // Reset during the second ACC cycle aborts; restart with start held high.
        do_reset();
        @(negedge clk);
        start = 1'b1;
        hidden = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_done", 32'(done), 32'd0);
        check("abort_out", 32'(out), 32'd0);
`ifdef TNNZEQ_SCORE_OUT_EN
        check("abort_scores", 32'(scores), 32'd0);
`endif
        hidden = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        wait_done(lat);
        check("abort_latency", 32'(lat), 32'd6);
        check("abort_result", 32'(out), 32'd0);

        // Hidden toggled during ACC is ignored; start held in DONE does not restart.
        do_reset();
        @(negedge clk);
        start = 1'b1;
        hidden = 4'b1111;
        @(posedge clk);
        #1;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            hidden = ~hidden;
            @(posedge clk);
            #1;
            lat++;
        end
        check("toggle_latency", 32'(lat), 32'd6);
        check("toggle_out", 32'(out), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            hidden = ~hidden;
            @(posedge clk);
            #1;
            check($sformatf("hold_done[%0d]", k), 32'(done), 32'd1);
            check($sformatf("hold_out[%0d]", k), 32'(out), 32'd0);
        end
`ifdef TNNZEQ_SCORE_OUT_EN
        check("hold_scores", 32'(scores), 32'h0C4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
